// File: rtl/ahb_sram_if.sv
// AHB-Lite bus bundle between the team's AHB master and the SRAM slave.
interface ahb_sram_if;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [1:0]  htrans;
  logic        hready;
  logic [31:0] hwdata;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, haddr, hwrite, hsize, hburst, htrans, hready, hwdata,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, hwrite, hsize, hburst, htrans, hready, hwdata,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite register-file memory slave with programmable wait states,
// byte/halfword/word writes and two-cycle ERROR on illegal accesses.
module ahb_sram_slave #(
  parameter int ADDR_WIDTH  = 4,
  parameter int WAIT_STATES = 1,
  parameter int USE_HTRANS  = 0
) (
  input logic       hclk,
  input logic       hresetn,
  ahb_sram_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t                state_q;
  logic                  hreadyout_q;
  logic                  hresp_q;
  logic                  write_q;
  logic [2:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] widx_q;
  logic [1:0]            lane_q;
  logic [1:0]            size_q;
  logic [31:0]           mem_q [DEPTH];

  logic        start;
  logic        out_of_range;
  logic        bad_size;
  logic        misaligned;
  logic        illegal;
  logic [3:0]  be_d;
  logic [31:0] wword_d;
  logic        unused_bus;

  assign start        = bus.hsel & bus.hready & hreadyout_q &
                        ((USE_HTRANS == 0) | bus.htrans[1]);
  assign out_of_range = |bus.haddr[31:ADDR_WIDTH+2];
  assign bad_size     = bus.hsize[2] | (&bus.hsize[1:0]);
  assign misaligned   = ((bus.hsize == 3'b001) && bus.haddr[0]) ||
                        ((bus.hsize == 3'b010) && (bus.haddr[1:0] != 2'b00));
  assign illegal      = out_of_range | bad_size | misaligned;
  assign unused_bus   = ^{bus.hburst, bus.htrans[0]};

  // Little-endian lane enables from the captured size and low address bits
  always_comb begin
    be_d    = 4'b1111;
    wword_d = mem_q[widx_q];
    case (size_q)
      2'd0:    be_d = 4'b0001 << lane_q;
      2'd1:    be_d = lane_q[1] ? 4'b1100 : 4'b0011;
      default: be_d = 4'b1111;
    endcase
    for (int b = 0; b < 4; b++) begin
      if (be_d[b]) wword_d[8*b +: 8] = bus.hwdata[8*b +: 8];
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q     <= S_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      write_q     <= 1'b0;
      cnt_q       <= 3'd0;
      widx_q      <= '0;
      lane_q      <= 2'd0;
      size_q      <= 2'd0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (state_q == S_DATA && write_q) mem_q[widx_q] <= wword_d;
      case (state_q)
        S_WAIT: begin
          if (cnt_q == 3'd0) begin
            state_q     <= S_DATA;
            hreadyout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        S_ERR1: begin
          state_q     <= S_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
        // IDLE, DATA and ERR2 all accept a new (possibly pipelined) start
        default: begin
          if (start) begin
            write_q <= bus.hwrite;
            widx_q  <= bus.haddr[ADDR_WIDTH+1:2];
            lane_q  <= bus.haddr[1:0];
            size_q  <= bus.hsize[1:0];
            if (illegal) begin
              state_q     <= S_ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              state_q     <= S_WAIT;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b0;
              cnt_q       <= WS_LOAD;
            end else begin
              state_q     <= S_DATA;
              hreadyout_q <= 1'b1;
              hresp_q     <= 1'b0;
            end
          end else begin
            state_q     <= S_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.hreadyout = hreadyout_q;
  assign bus.hresp     = hresp_q;
  assign bus.hrdata    = (state_q == S_DATA && !write_q) ? mem_q[widx_q] : 32'd0;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: instance 0 with one wait state, instance 1 with none,
// each shadowed by a transfer-level model checked every cycle.
module tb_ahb_sram_slave;
  logic hclk = 1'b0;
  logic hresetn = 1'b0;
  always #5 hclk = ~hclk;

  logic        hsel_r   [2];
  logic        hwrite_r [2];
  logic [31:0] haddr_r  [2];
  logic [2:0]  hsize_r  [2];
  logic [31:0] hwdata_r [2];
  logic        rdy_w    [2];
  logic        resp_w   [2];
  logic [31:0] rdata_w  [2];

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic       rdy;
    logic       resp;
    logic       rd;
    logic       wr;
    logic [3:0] widx;
    logic [1:0] lo;
    logic [2:0] nb;
  } exp_t;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int WS = (g == 0) ? 1 : 0;
    ahb_sram_if bus ();
    assign bus.hsel   = hsel_r[g];
    assign bus.haddr  = haddr_r[g];
    assign bus.hwrite = hwrite_r[g];
    assign bus.hsize  = hsize_r[g];
    assign bus.hburst = 3'b000;
    assign bus.htrans = 2'b10;
    assign bus.hready = 1'b1;
    assign bus.hwdata = hwdata_r[g];
    assign rdy_w[g]   = bus.hreadyout;
    assign resp_w[g]  = bus.hresp;
    assign rdata_w[g] = bus.hrdata;

    ahb_sram_slave #(.ADDR_WIDTH(4), .WAIT_STATES(WS), .USE_HTRANS(0)) dut (
      .hclk(hclk), .hresetn(hresetn), .bus(bus.slave)
    );

    // Model: queue of expected per-cycle responses plus a word array
    exp_t        mq[$];
    logic [31:0] mem[16];

    initial begin : model
      exp_t        cur, e;
      int unsigned a, nb;
      bit          bad;
      forever begin
        @(posedge hclk or negedge hresetn);
        if (!hresetn) begin
          mq.delete();
          for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        end else begin
          cur = '0;
          cur.rdy = 1'b1;
          if (mq.size() > 0) cur = mq.pop_front();
          if (cur.wr) begin
            for (int b = 0; b < 4; b++)
              if (b >= cur.lo && b < cur.lo + cur.nb) mem[cur.widx][8*b +: 8] = hwdata_r[g][8*b +: 8];
          end
          if (cur.rdy && hsel_r[g]) begin
            a   = haddr_r[g];
            nb  = (hsize_r[g] <= 3'd2) ? (1 << hsize_r[g]) : 1;
            bad = (a >= 64) || (hsize_r[g] > 3'd2) || (a % nb != 0);
            if (bad) begin
              e = '0; e.resp = 1'b1; mq.push_back(e);
              e.rdy = 1'b1;          mq.push_back(e);
            end else begin
              for (int k = 0; k < WS; k++) begin
                e = '0; mq.push_back(e);
              end
              e = '0;
              e.rdy  = 1'b1;
              e.rd   = !hwrite_r[g];
              e.wr   = hwrite_r[g];
              e.widx = 4'(a / 4);
              e.lo   = 2'(a % 4);
              e.nb   = 3'(nb);
              mq.push_back(e);
            end
          end
        end
      end
    end

    initial begin : compare
      exp_t        e;
      logic [31:0] erd;
      forever begin
        @(negedge hclk);
        if (hresetn) begin
          e = '0;
          e.rdy = 1'b1;
          if (mq.size() > 0) e = mq[0];
          erd = e.rd ? mem[e.widx] : 32'd0;
          n_chk++;
          if (rdy_w[g] !== e.rdy || resp_w[g] !== e.resp || rdata_w[g] !== erd) begin
            n_fail++;
            $display("FAIL cyc_ws%0d t=%0t: got rdy=%b resp=%b rdata=%h, want rdy=%b resp=%b rdata=%h",
                     WS, $time, rdy_w[g], resp_w[g], rdata_w[g], e.rdy, e.resp, erd);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp_v);
    end
  endtask

  // One non-pipelined transfer; returns data-phase rdata/hresp and count of low-hreadyout cycles
  task automatic xfer(input int i, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd, output logic rsp, output int lows);
    @(negedge hclk);
    hsel_r[i] = 1'b1; hwrite_r[i] = wr; haddr_r[i] = a; hsize_r[i] = sz;
    @(negedge hclk);
    hsel_r[i] = 1'b0; hwdata_r[i] = wd;
    lows = 0;
    while (!rdy_w[i] && lows < 20) begin
      lows++;
      @(negedge hclk);
    end
    if (lows >= 20) chk("xfer_timeout", 32'(lows), 32'd0);
    rd = rdata_w[i]; rsp = resp_w[i];
  endtask

  logic [31:0] rd;
  logic        rsp;
  int          lows;

  initial begin
    for (int i = 0; i < 2; i++) begin
      hsel_r[i] = 1'b0; hwrite_r[i] = 1'b0; haddr_r[i] = '0; hsize_r[i] = '0; hwdata_r[i] = '0;
    end
    repeat (2) @(negedge hclk);
    chk("reset_rdy", 32'(rdy_w[0]), 32'd1);
    chk("reset_resp", 32'(resp_w[0]), 32'd0);
    chk("reset_rdata", rdata_w[0], 32'd0);
    hresetn = 1'b1;

    // Word write then read with one wait state
    xfer(0, 1, 32'h04, 3'b010, 32'hDEADBEEF, rd, rsp, lows);
    chk("wr_lows", 32'(lows), 32'd1);
    chk("wr_resp", 32'(rsp), 32'd0);
    xfer(0, 0, 32'h04, 3'b010, 32'h0, rd, rsp, lows);
    chk("rd_lows", 32'(lows), 32'd1);
    chk("rd_data", rd, 32'hDEADBEEF);
    chk("rd_resp", 32'(rsp), 32'd0);

    // Byte and halfword lane merges
    xfer(0, 1, 32'h04, 3'b010, 32'h11223344, rd, rsp, lows);
    xfer(0, 1, 32'h05, 3'b000, 32'h0000AA00, rd, rsp, lows);
    xfer(0, 1, 32'h0A, 3'b001, 32'h55660000, rd, rsp, lows);
    xfer(0, 0, 32'h04, 3'b010, 32'h0, rd, rsp, lows);
    chk("byte_merge", rd, 32'h1122AA44);
    xfer(0, 0, 32'h08, 3'b010, 32'h0, rd, rsp, lows);
    chk("half_merge", rd, 32'h55660000);

    // Illegal accesses: out of range, misaligned halfword/word, bad size
    xfer(0, 1, 32'h40, 3'b010, 32'hFFFFFFFF, rd, rsp, lows);
    chk("oor_resp", 32'(rsp), 32'd1);
    chk("oor_lows", 32'(lows), 32'd1);
    xfer(0, 0, 32'h00, 3'b010, 32'h0, rd, rsp, lows);
    chk("oor_mem_unchanged", rd, 32'd0);
    xfer(0, 1, 32'h03, 3'b001, 32'hFFFFFFFF, rd, rsp, lows);
    chk("mis_half_resp", 32'(rsp), 32'd1);
    xfer(0, 1, 32'h06, 3'b010, 32'hFFFFFFFF, rd, rsp, lows);
    chk("mis_word_resp", 32'(rsp), 32'd1);
    xfer(0, 0, 32'h00, 3'b011, 32'h0, rd, rsp, lows);
    chk("bad_size_resp", 32'(rsp), 32'd1);
    xfer(0, 0, 32'h00, 3'b010, 32'h0, rd, rsp, lows);
    chk("after_err_resp", 32'(rsp), 32'd0);
    chk("after_err_data", rd, 32'd0);
    xfer(0, 0, 32'h04, 3'b010, 32'h0, rd, rsp, lows);
    chk("after_err_word4", rd, 32'h1122AA44);

    // Zero wait states: pipelined write then read of the same word
    xfer(1, 1, 32'h08, 3'b010, 32'h01020304, rd, rsp, lows);
    chk("ws0_lows", 32'(lows), 32'd0);
    @(negedge hclk);
    hsel_r[1] = 1'b1; hwrite_r[1] = 1'b1; haddr_r[1] = 32'h0C; hsize_r[1] = 3'b010;
    @(negedge hclk);
    chk("ws0_wr_rdy", 32'(rdy_w[1]), 32'd1);
    hwdata_r[1] = 32'h0000CAFE; hwrite_r[1] = 1'b0;
    @(negedge hclk);
    hsel_r[1] = 1'b0;
    chk("ws0_rd_rdy", 32'(rdy_w[1]), 32'd1);
    chk("ws0_rd_data", rdata_w[1], 32'h0000CAFE);
    chk("ws0_rd_resp", 32'(resp_w[1]), 32'd0);

    // Asynchronous reset during the wait cycle of a write
    @(negedge hclk);
    hsel_r[0] = 1'b1; hwrite_r[0] = 1'b1; haddr_r[0] = 32'h10; hsize_r[0] = 3'b010;
    hwdata_r[0] = 32'h12345678;
    @(negedge hclk);
    hsel_r[0] = 1'b0;
    chk("pre_rst_wait", 32'(rdy_w[0]), 32'd0);
    #2 hresetn = 1'b0;
    #1;
    chk("async_rst_rdy", 32'(rdy_w[0]), 32'd1);
    chk("async_rst_resp", 32'(resp_w[0]), 32'd0);
    chk("async_rst_rdata", rdata_w[0], 32'd0);
    @(negedge hclk);
    hresetn = 1'b1;
    xfer(0, 0, 32'h10, 3'b010, 32'h0, rd, rsp, lows);
    chk("rst_discard_wr", rd, 32'd0);
    xfer(0, 0, 32'h04, 3'b010, 32'h0, rd, rsp, lows);
    chk("rst_clears_mem", rd, 32'd0);

    repeat (2) @(negedge hclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB-Lite memory slave sitting directly downstream of the team's AHB master: it consumes `haddr/hwrite/hsize/hwdata` and produces `hreadyout/hresp/hrdata` back to it. It holds a small register-file memory, inserts a programmable number of wait states per transfer, supports byte/halfword/word writes, and flags illegal accesses with the two-cycle AHB ERROR response.

## Interface
- `ADDR_WIDTH`, 4, word-index width; memory depth = 2**ADDR_WIDTH 32-bit words (byte range 0 .. 4*2**ADDR_WIDTH-1).
- `WAIT_STATES`, 1, wait cycles (hreadyout low) per OKAY transfer; legal 0..7.
- `USE_HTRANS`, 0, 1 = additionally require `htrans[1]` (NONSEQ/SEQ) to start a transfer; 0 = htrans ignored.

- `hclk` in 1: clock, all state on rising edge.
- `hresetn` in 1: reset hresetn, asynchronous, active-low; clock hclk.
- `hsel` in 1: slave select (decoded from master `sel`).
- `haddr` in 32: byte address, address phase.
- `hwrite` in 1: 1 = write, 0 = read.
- `hsize` in 3: 000 byte, 001 halfword, 010 word; others illegal.
- `hburst` in 3: accepted, unused (every beat handled as a single transfer).
- `htrans` in 2: transfer type, used only when USE_HTRANS=1.
- `hready` in 1: master-side transfer-valid/ready qualifier.
- `hwdata` in 32: write data, data phase.
- `hreadyout` out 1: 1 = data phase completes this cycle / slave free.
- `hresp` out 1: 0 OKAY, 1 ERROR.
- `hrdata` out 32: read data, valid when `hreadyout`=1 in a read data phase.

## Operation
- Start condition: `hsel & hready & hreadyout` (and `htrans[1]` if USE_HTRANS=1), sampled at a rising edge. The slave registers addr, hwrite and hsize.
- Legality check at the start edge:
  - ERROR if `haddr[31:ADDR_WIDTH+2]` != 0 (out of range).
  - ERROR if `hsize` > 010.
  - ERROR if misaligned: halfword with `haddr[0]`=1; word with `haddr[1:0]` != 0.
- FSM states:
  - IDLE: `hreadyout`=1, `hresp`=0. On a legal start, go to WAIT if WAIT_STATES>0, else DATA. On an illegal start, go to ERR1.
  - WAIT: `hreadyout`=0, `hresp`=0. A counter loads WAIT_STATES-1 and decrements. Go to DATA when the counter reaches 0.
  - DATA: `hreadyout`=1, `hresp`=0; final data-phase cycle.
    - Write: commit `hwdata` lanes selected by the captured size/addr[1:0] at the closing edge.
    - Read: `hrdata` = mem[captured word index], whole word, combinational.
    - A new start in DATA is accepted (pipelined), giving back-to-back transfers with the same next-state rules as IDLE. Otherwise go to IDLE.
  - ERR1: `hreadyout`=0, `hresp`=1. Go to ERR2.
  - ERR2: `hreadyout`=1, `hresp`=1; no memory write. A start here is evaluated as in DATA.
- Byte lanes (little-endian):
  - byte: lane = addr[1:0].
  - halfword: lanes {addr[1],0} and {addr[1],1}.
  - word: all four lanes.
  - Unselected lanes are unchanged.
- `hrdata` = 0 in every cycle except a read DATA cycle.
- `hburst` is ignored; bursts appear as successive single transfers.

## Timing
- Reset, asynchronous: state=IDLE, `hreadyout`=1, `hresp`=0, `hrdata`=0, wait counter 0, all memory words 0.
- OKAY latency: start edge, then WAIT_STATES low cycles, then 1 DATA cycle. Throughput is one transfer per WAIT_STATES+1 cycles.
- ERROR: always exactly 2 cycles (ERR1, ERR2) regardless of WAIT_STATES.
- Starts are not sampled while `hreadyout`=0 (WAIT, ERR1). Address/control may change freely there.
- Read-after-write to the same address back-to-back: the write commits at the edge that starts the read. The read data phase returns the new value; no forwarding needed.
- `hsel` dropping mid-transfer does not abort it; the data phase runs to completion.
- Reset mid-transfer: immediate return to IDLE, pending write discarded, memory cleared.

## Test plan
- Reset, then with WAIT_STATES=1: write word 0xDEADBEEF to 0x04, then read 0x04. Required: `hreadyout` low 1 cycle per transfer, read `hrdata`=0xDEADBEEF, `hresp`=0.
- Byte write 0xAA to 0x05 over the word 0x11223344 at 0x04, then halfword write 0x5566 to 0x0A over 0. Required: reads return 0x1122AA44 at 0x04 and 0x55660000 at 0x08.
- Out-of-range access to 0x40 (ADDR_WIDTH=4), word write. Required: ERR1 (`hreadyout`=0, `hresp`=1), then ERR2 (`hreadyout`=1, `hresp`=1); memory unchanged.
- Misaligned halfword at 0x03, and `hsize`=011 at 0x00. Required: both give the two-cycle ERROR; a following legal read of 0x00 returns OKAY.
- WAIT_STATES=0, back-to-back write 0x0000CAFE to 0x0C then read 0x0C. Required: `hreadyout` stays 1 throughout; the read returns 0x0000CAFE in the cycle after the write data phase.
- Assert hresetn low during a WAIT cycle of a write. Required: outputs return to their reset values asynchronously and the target word reads 0 after reset.
